lsu_issue_arb: RTL and testbench

- Arbiter/scheduler that shares the single two-stage LSU functional unit between the load reservation station (LD) and the store reservation station (ST).
- Selects at most one memory op per cycle, oldest-first by ROB age, with a starvation override.
- Blocks stores while the store buffer is full and runs a post-mispredict drain before re-issuing.
- Issue payload is registered and drives the LSU exe_v/opcode/operand/imm/dest inputs directly.

---
 rtl/lsu_issue_arb.sv | 170 +++++++++++++++++
 tb/tb_lsu_issue_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_issue_arb
// Brief    : Oldest-first LD/ST issue arbiter for the shared LSU, with
//            starvation override, store-buffer gating and mispredict drain.
// Revision : 1.0
// ============================================================================
module lsu_issue_arb #(
    parameter int WORD_SIZE_P  = 16,
    parameter int WIDTH_OP     = 4,
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_PHYS_REG = 32,
    parameter int SB_ENTRY     = 8,
    parameter int STARVE_MAX   = 4,
    parameter int FLUSH_CYCLES = 2,
    localparam int c_rob_w = $clog2(ROB_ENTRY),
    localparam int c_reg_w = $clog2(NUM_PHYS_REG),
    localparam int c_sb_w  = $clog2(SB_ENTRY),
    localparam int c_pkt_w = WIDTH_OP + 3*WORD_SIZE_P + c_rob_w + c_reg_w + c_sb_w
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   ld_v_i,
    input  logic [c_pkt_w-1:0]     ld_pkt_i,
    output logic                   ld_ready_o,
    input  logic                   st_v_i,
    input  logic [c_pkt_w-1:0]     st_pkt_i,
    output logic                   st_ready_o,
    input  logic [c_rob_w-1:0]     rob_head_i,
    input  logic                   sb_full_i,
    input  logic                   mispredict_i,
    output logic                   exe_v_o,
    output logic [WIDTH_OP-1:0]    opcode_o,
    output logic [WORD_SIZE_P-1:0] operand1_o,
    output logic [WORD_SIZE_P-1:0] operand2_o,
    output logic [WORD_SIZE_P-1:0] imm_o,
    output logic [c_rob_w-1:0]     rob_dest_o,
    output logic [c_reg_w-1:0]     reg_dest_o,
    output logic [c_sb_w-1:0]      sb_dest_o,
    output logic                   busy_o
);

    localparam int c_reg_lo = c_sb_w;
    localparam int c_rob_lo = c_reg_lo + c_reg_w;
    localparam int c_imm_lo = c_rob_lo + c_rob_w;
    localparam int c_op2_lo = c_imm_lo + WORD_SIZE_P;
    localparam int c_op1_lo = c_op2_lo + WORD_SIZE_P;
    localparam int c_opc_lo = c_op1_lo + WORD_SIZE_P;
    localparam int c_stv_w  = $clog2(STARVE_MAX + 1);
    localparam int c_fl_w   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_stv_w-1:0] c_stv_max  = c_stv_w'(STARVE_MAX);
    localparam logic [c_fl_w-1:0]  c_fl_load  = c_fl_w'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_fl_w-1:0]    r_flush_cnt;
    logic [c_stv_w-1:0]   r_ld_starve;
    logic [c_stv_w-1:0]   r_st_starve;
    logic                 r_exe_v;
    logic [c_pkt_w-1:0]   r_pkt;

    logic                 w_run;
    logic                 w_ld_elig;
    logic                 w_st_elig;
    logic [c_rob_w-1:0]   w_ld_age;
    logic [c_rob_w-1:0]   w_st_age;
    logic                 w_gnt_ld;
    logic                 w_gnt_st;

    // Reset is folded in so the ready outputs are low while held in reset.
    always_comb begin
        w_run     = reset_n_i && (r_state == ST_RUN) && !mispredict_i;
        w_ld_elig = ld_v_i && w_run;
        w_st_elig = st_v_i && !sb_full_i && w_run;
        w_ld_age  = ld_pkt_i[c_rob_lo +: c_rob_w] - rob_head_i;
        w_st_age  = st_pkt_i[c_rob_lo +: c_rob_w] - rob_head_i;
        w_gnt_ld  = 1'b0;
        w_gnt_st  = 1'b0;
        if (w_ld_elig && !w_st_elig) begin
            w_gnt_ld = 1'b1;
        end else if (w_st_elig && !w_ld_elig) begin
            w_gnt_st = 1'b1;
        end else if (w_ld_elig && w_st_elig) begin
            if (r_ld_starve == c_stv_max) begin
                w_gnt_ld = 1'b1;
            end else if (r_st_starve == c_stv_max) begin
                w_gnt_st = 1'b1;
            end else if (w_st_age < w_ld_age) begin
                w_gnt_st = 1'b1;
            end else begin
                w_gnt_ld = 1'b1;
            end
        end
    end

    assign ld_ready_o = w_gnt_ld;
    assign st_ready_o = w_gnt_st;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_ld_starve <= '0;
            r_st_starve <= '0;
            r_exe_v     <= 1'b0;
            r_pkt       <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mispredict_i) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= c_fl_load;
                    end
                end
                ST_FLUSH: begin
                    if (mispredict_i) begin
                        r_flush_cnt <= c_fl_load;
                    end else if (r_flush_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            // Starvation only accrues between competing eligible requests.
            if (!w_run) begin
                r_ld_starve <= '0;
                r_st_starve <= '0;
            end else begin
                if (w_gnt_ld || !ld_v_i) begin
                    r_ld_starve <= '0;
                end else if (r_ld_starve != c_stv_max) begin
                    r_ld_starve <= r_ld_starve + 1'b1;
                end

                if (w_gnt_st || !st_v_i) begin
                    r_st_starve <= '0;
                end else if (!sb_full_i && r_st_starve != c_stv_max) begin
                    r_st_starve <= r_st_starve + 1'b1;
                end
            end

            r_exe_v <= w_gnt_ld || w_gnt_st;
            if (w_gnt_st) begin
                r_pkt <= st_pkt_i;
            end else if (w_gnt_ld) begin
                r_pkt <= ld_pkt_i;
            end
        end
    end

    assign exe_v_o    = r_exe_v;
    assign opcode_o   = r_pkt[c_opc_lo +: WIDTH_OP];
    assign operand1_o = r_pkt[c_op1_lo +: WORD_SIZE_P];
    assign operand2_o = r_pkt[c_op2_lo +: WORD_SIZE_P];
    assign imm_o      = r_pkt[c_imm_lo +: WORD_SIZE_P];
    assign rob_dest_o = r_pkt[c_rob_lo +: c_rob_w];
    assign reg_dest_o = r_pkt[c_reg_lo +: c_reg_w];
    assign sb_dest_o  = r_pkt[c_sb_w-1:0];
    assign busy_o     = (r_state == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_lsu_issue_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu_issue_arb
// Brief    : Directed vector bench for lsu_issue_arb.
// Revision : 1.0
// ============================================================================
module tb_lsu_issue_arb;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        ld_v_i, st_v_i, sb_full_i, mispredict_i;
    logic [63:0] ld_pkt_i, st_pkt_i;
    logic [3:0]  rob_head_i;
    logic        ld_ready_o, st_ready_o, exe_v_o, busy_o;
    logic [3:0]  opcode_o;
    logic [15:0] operand1_o, operand2_o, imm_o;
    logic [3:0]  rob_dest_o;
    logic [4:0]  reg_dest_o;
    logic [2:0]  sb_dest_o;

    int checks   = 0;
    int failures = 0;

    lsu_issue_arb dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .ld_v_i(ld_v_i), .ld_pkt_i(ld_pkt_i), .ld_ready_o(ld_ready_o),
        .st_v_i(st_v_i), .st_pkt_i(st_pkt_i), .st_ready_o(st_ready_o),
        .rob_head_i(rob_head_i), .sb_full_i(sb_full_i), .mispredict_i(mispredict_i),
        .exe_v_o(exe_v_o), .opcode_o(opcode_o), .operand1_o(operand1_o),
        .operand2_o(operand2_o), .imm_o(imm_o), .rob_dest_o(rob_dest_o),
        .reg_dest_o(reg_dest_o), .sb_dest_o(sb_dest_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] head;
        logic [3:0] ld_rob;
        logic [3:0] st_rob;
        logic       ld_v;
        logic       st_v;
        logic       sb_full;
        logic       e_ld;
        logic       e_st;
        logic       e_exe;
        logic [3:0] e_rob;
        logic [3:0] e_op;
    } vec_t;

    vec_t vt[10];

    // LD payloads carry opcode 3, ST payloads opcode 9; other fields derive from rob.
    function automatic logic [63:0] mk_pkt(input logic [3:0] rob, input logic side);
        logic [3:0] op;
        op = side ? 4'h9 : 4'h3;
        return {op, 16'h1000 + {12'h0, rob}, 16'h2000 + {12'h0, rob},
                16'h3000 + {12'h0, rob}, rob, {side, rob}, rob[2:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic lv, input logic [3:0] lrob,
                           input logic sv, input logic [3:0] srob);
        ld_v_i   = lv;
        st_v_i   = sv;
        ld_pkt_i = mk_pkt(lrob, 1'b0);
        st_pkt_i = mk_pkt(srob, 1'b1);
    endtask

    task automatic idle;
        ld_v_i = 1'b0; st_v_i = 1'b0; sb_full_i = 1'b0; mispredict_i = 1'b0;
        tick();
    endtask

    initial begin
        vt[0] = '{4'd0,  4'd5,  4'd0,  1, 0, 0, 1, 0, 1, 4'd5,  4'h3};
        vt[1] = '{4'd0,  4'd0,  4'd6,  0, 1, 0, 0, 1, 1, 4'd6,  4'h9};
        vt[2] = '{4'd0,  4'd2,  4'd7,  1, 1, 0, 1, 0, 1, 4'd2,  4'h3};
        vt[3] = '{4'd0,  4'd9,  4'd4,  1, 1, 0, 0, 1, 1, 4'd4,  4'h9};
        vt[4] = '{4'd14, 4'd1,  4'd15, 1, 1, 0, 0, 1, 1, 4'd15, 4'h9};
        vt[5] = '{4'd14, 4'd13, 4'd0,  1, 1, 0, 0, 1, 1, 4'd0,  4'h9};
        vt[6] = '{4'd3,  4'd5,  4'd5,  1, 1, 0, 1, 0, 1, 4'd5,  4'h3};
        vt[7] = '{4'd0,  4'd8,  4'd2,  1, 1, 1, 1, 0, 1, 4'd8,  4'h3};
        vt[8] = '{4'd0,  4'd0,  4'd2,  0, 1, 1, 0, 0, 0, 4'd8,  4'h3};
        vt[9] = '{4'd0,  4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd8,  4'h3};

        // Reset, with a load request pending throughout.
        reset_n_i = 1'b0; sb_full_i = 1'b0; mispredict_i = 1'b0; rob_head_i = 4'd0;
        set_req(1'b1, 4'd3, 1'b0, 4'd0);
        #12;
        chk("rst_exe_v", exe_v_o, 0);
        chk("rst_rob", rob_dest_o, 0);
        chk("rst_opcode", opcode_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ld_ready", ld_ready_o, 0);
        reset_n_i = 1'b1;
        #1;
        chk("rel_ld_ready", ld_ready_o, 1);
        tick();
        chk("first_exe_v", exe_v_o, 1);
        chk("first_rob", rob_dest_o, 3);

        // Asynchronous reset mid-issue clears outputs without a clock edge.
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_exe_v", exe_v_o, 0);
        chk("async_rob", rob_dest_o, 0);
        chk("async_imm", imm_o, 0);
        #1 reset_n_i = 1'b1;
        tick();
        chk("post_rst_exe_v", exe_v_o, 1);
        chk("post_rst_rob", rob_dest_o, 3);
        idle();

        for (int i = 0; i < 10; i++) begin
            rob_head_i = vt[i].head;
            sb_full_i  = vt[i].sb_full;
            set_req(vt[i].ld_v, vt[i].ld_rob, vt[i].st_v, vt[i].st_rob);
            #1;
            chk($sformatf("v%0d_ld_ready", i), ld_ready_o, vt[i].e_ld);
            chk($sformatf("v%0d_st_ready", i), st_ready_o, vt[i].e_st);
            tick();
            chk($sformatf("v%0d_exe_v", i), exe_v_o, vt[i].e_exe);
            chk($sformatf("v%0d_rob", i), rob_dest_o, vt[i].e_rob);
            chk($sformatf("v%0d_opcode", i), opcode_o, vt[i].e_op);
            if (vt[i].e_exe) begin
                chk($sformatf("v%0d_imm", i), imm_o, 16'h3000 + {12'h0, vt[i].e_rob});
                chk($sformatf("v%0d_reg", i), reg_dest_o, {vt[i].e_st, vt[i].e_rob});
                chk($sformatf("v%0d_op1", i), operand1_o, 16'h1000 + {12'h0, vt[i].e_rob});
            end
            idle();
        end

        // Starvation: LD always older; ST wins on the fifth contested cycle.
        rob_head_i = 4'd0;
        set_req(1'b1, 4'd1, 1'b1, 4'd9);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("starve%0d_ld_ready", c), ld_ready_o, (c == 4) ? 1'b0 : 1'b1);
            chk($sformatf("starve%0d_st_ready", c), st_ready_o, (c == 4) ? 1'b1 : 1'b0);
            tick();
            chk($sformatf("starve%0d_rob", c), rob_dest_o, (c == 4) ? 4'd9 : 4'd1);
        end
        idle();

        // Store buffer full blocks a lone store until it drains.
        sb_full_i = 1'b1;
        set_req(1'b0, 4'd0, 1'b1, 4'd11);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("sbfull%0d_st_ready", c), st_ready_o, 0);
            tick();
            chk($sformatf("sbfull%0d_exe_v", c), exe_v_o, 0);
        end
        sb_full_i = 1'b0;
        #1;
        chk("sbdrop_st_ready", st_ready_o, 1);
        tick();
        chk("sbdrop_exe_v", exe_v_o, 1);
        chk("sbdrop_rob", rob_dest_o, 11);
        chk("sbdrop_sb_dest", sb_dest_o, 3);
        idle();

        // Mispredict pulse while issuing.
        set_req(1'b1, 4'd2, 1'b1, 4'd5);
        tick();
        chk("mp_pre_exe_v", exe_v_o, 1);
        mispredict_i = 1'b1;
        #1;
        chk("mp_ld_ready", ld_ready_o, 0);
        chk("mp_st_ready", st_ready_o, 0);
        tick();
        mispredict_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("flush%0d_busy", c), busy_o, 1);
            chk($sformatf("flush%0d_exe_v", c), exe_v_o, 0);
            chk($sformatf("flush%0d_ready", c), {ld_ready_o, st_ready_o}, 0);
            tick();
        end
        chk("resume_busy", busy_o, 0);
        chk("resume_exe_v", exe_v_o, 0);
        chk("resume_ld_ready", ld_ready_o, 1);
        tick();
        chk("resume_issue", exe_v_o, 1);

        // Second pulse during the first FLUSH cycle reloads the drain.
        mispredict_i = 1'b1;
        tick();
        chk("mp2_busy_a", busy_o, 1);
        tick();
        mispredict_i = 1'b0;
        chk("mp2_busy_b", busy_o, 1);
        tick();
        chk("mp2_busy_c", busy_o, 1);
        chk("mp2_exe_v_c", exe_v_o, 0);
        tick();
        chk("mp2_run", busy_o, 0);
        chk("mp2_ld_ready", ld_ready_o, 1);
        tick();
        chk("mp2_issue", exe_v_o, 1);
        idle();

        // Back-to-back load stream with no bubbles.
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 4'(i), 1'b0, 4'd0);
            #1;
            chk($sformatf("stream%0d_ready", i), ld_ready_o, 1);
            tick();
            chk($sformatf("stream%0d_exe_v", i), exe_v_o, 1);
            chk($sformatf("stream%0d_rob", i), rob_dest_o, 4'(i));
        end
        idle();
        chk("stream_end_exe_v", exe_v_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
